// File: rtl/pll_ctrl_if.sv
// Reconfiguration request/acknowledge bundle between a host and pll_ctrl.
interface pll_ctrl_if;
  logic       cfg_req;
  logic [2:0] cfg_ch;
  logic [9:0] cfg_odiv;
  logic [9:0] cfg_duty;
  logic       cfg_ack;
  logic       cfg_err;

  modport master (output cfg_req, cfg_ch, cfg_odiv, cfg_duty, input cfg_ack, cfg_err);
  modport slave  (input cfg_req, cfg_ch, cfg_odiv, cfg_duty, output cfg_ack, cfg_err);
endinterface

// File: rtl/pll_ctrl.sv
// PLL bring-up sequencer with lock supervision, retry/fault handling and
// glitch-free per-channel output divider reconfiguration.
module pll_ctrl #(
  parameter int unsigned PWD_CYCLES   = 16,
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned LOCK_FILTER  = 8,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned GATE_CYCLES  = 4,
  parameter logic [9:0]  INIT_ODIV    = 10'd100,
  parameter logic [9:0]  INIT_DUTY    = 10'd100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pll_lock,
  pll_ctrl_if.slave        cfg,
  output logic             pll_pwd,
  output logic             pll_rst,
  output logic             rstodiv,
  output logic [4:0]       clkout_gate,
  output logic [49:0]      dyn_odiv,
  output logic [49:0]      dyn_duty,
  output logic             ready,
  output logic             fault,
  output logic             lock_lost
);

  localparam int unsigned PR_MAX  = (PWD_CYCLES > RST_CYCLES) ? PWD_CYCLES : RST_CYCLES;
  localparam int unsigned SEQ_MAX = (PR_MAX > GATE_CYCLES) ? PR_MAX : GATE_CYCLES;
  localparam int unsigned SW = $clog2(SEQ_MAX + 1);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned FW = $clog2(LOCK_FILTER + 1);
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  localparam logic [SW-1:0] PWD_LAST   = SW'(PWD_CYCLES - 1);
  localparam logic [SW-1:0] RST_LAST   = SW'(RST_CYCLES - 1);
  localparam logic [SW-1:0] GATE_LAST  = SW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(LOCK_TIMEOUT - 1);
  localparam logic [FW-1:0] FILT_LAST  = FW'(LOCK_FILTER - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  typedef enum logic [3:0] {
    IDLE, PWD, RST, WAIT_LOCK, RUN, CFG_PRE, CFG_APPLY, CFG_POST, FAULT
  } state_t;

  state_t        state;
  logic          lock_meta, lock_s, low_seen, lock_drop, req_armed;
  logic [SW-1:0] seq_cnt;
  logic [TW-1:0] to_cnt;
  logic [FW-1:0] filt_cnt;
  logic [RW-1:0] retry_cnt;
  logic [2:0]    cap_ch;
  logic [9:0]    cap_odiv, cap_duty;

  // Second consecutive synchronized low while running declares loss.
  always_comb begin
    lock_drop = low_seen && !lock_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lock_meta   <= 1'b0;
      lock_s      <= 1'b0;
      low_seen    <= 1'b0;
      req_armed   <= 1'b1;
      seq_cnt     <= '0;
      to_cnt      <= '0;
      filt_cnt    <= '0;
      retry_cnt   <= '0;
      cap_ch      <= '0;
      cap_odiv    <= '0;
      cap_duty    <= '0;
      pll_pwd     <= 1'b1;
      pll_rst     <= 1'b1;
      rstodiv     <= 1'b0;
      clkout_gate <= '1;
      dyn_odiv    <= {5{INIT_ODIV}};
      dyn_duty    <= {5{INIT_DUTY}};
      ready       <= 1'b0;
      fault       <= 1'b0;
      lock_lost   <= 1'b0;
      cfg.cfg_ack <= 1'b0;
      cfg.cfg_err <= 1'b0;
    end else begin
      lock_meta   <= pll_lock;
      lock_s      <= lock_meta;
      lock_lost   <= 1'b0;
      cfg.cfg_ack <= 1'b0;
      cfg.cfg_err <= 1'b0;
      if (!cfg.cfg_req) req_armed <= 1'b1;
      if (state inside {RUN, CFG_PRE, CFG_APPLY, CFG_POST}) low_seen <= !lock_s;
      else                                                  low_seen <= 1'b0;

      case (state)
        IDLE: if (start) begin
          state   <= PWD;
          seq_cnt <= '0;
        end

        PWD: if (seq_cnt == PWD_LAST) begin
          state   <= RST;
          seq_cnt <= '0;
          pll_pwd <= 1'b0;
        end else seq_cnt <= seq_cnt + SW'(1);

        RST: if (seq_cnt == RST_LAST) begin
          state    <= WAIT_LOCK;
          seq_cnt  <= '0;
          pll_rst  <= 1'b0;
          to_cnt   <= '0;
          filt_cnt <= '0;
        end else seq_cnt <= seq_cnt + SW'(1);

        WAIT_LOCK: begin
          if (lock_s && filt_cnt == FILT_LAST) begin
            state       <= RUN;
            clkout_gate <= '0;
            ready       <= 1'b1;
            retry_cnt   <= '0;
          end else if (to_cnt == TO_LAST) begin
            pll_pwd <= 1'b1;
            pll_rst <= 1'b1;
            seq_cnt <= '0;
            if (retry_cnt == RETRY_LAST) begin
              state     <= FAULT;
              fault     <= 1'b1;
              retry_cnt <= RW'(MAX_RETRY);
            end else begin
              state     <= PWD;
              retry_cnt <= retry_cnt + RW'(1);
            end
          end else begin
            to_cnt   <= to_cnt + TW'(1);
            filt_cnt <= lock_s ? filt_cnt + FW'(1) : '0;
          end
        end

        RUN, CFG_PRE, CFG_APPLY, CFG_POST: begin
          if (lock_drop) begin
            state       <= RST;
            seq_cnt     <= '0;
            pll_rst     <= 1'b1;
            rstodiv     <= 1'b0;
            clkout_gate <= '1;
            ready       <= 1'b0;
            lock_lost   <= 1'b1;
            low_seen    <= 1'b0;
            if (state != RUN) begin
              cfg.cfg_ack <= 1'b1;
              cfg.cfg_err <= 1'b1;
              req_armed   <= 1'b0;
            end
          end else begin
            case (state)
              RUN: if (cfg.cfg_req && req_armed) begin
                if (cfg.cfg_ch > 3'd4 || cfg.cfg_odiv == '0) begin
                  cfg.cfg_ack <= 1'b1;
                  cfg.cfg_err <= 1'b1;
                  req_armed   <= 1'b0;
                end else begin
                  state       <= CFG_PRE;
                  seq_cnt     <= '0;
                  cap_ch      <= cfg.cfg_ch;
                  cap_odiv    <= cfg.cfg_odiv;
                  cap_duty    <= cfg.cfg_duty;
                  clkout_gate <= 5'b00001 << cfg.cfg_ch;
                end
              end

              CFG_PRE: if (seq_cnt == GATE_LAST) begin
                state   <= CFG_APPLY;
                seq_cnt <= '0;
                rstodiv <= 1'b1;
                for (int unsigned n = 0; n < 5; n++) begin
                  if (cap_ch == 3'(n)) begin
                    dyn_odiv[10*n +: 10] <= cap_odiv;
                    dyn_duty[10*n +: 10] <= cap_duty;
                  end
                end
              end else seq_cnt <= seq_cnt + SW'(1);

              CFG_APPLY: if (seq_cnt == RST_LAST) begin
                state   <= CFG_POST;
                seq_cnt <= '0;
                rstodiv <= 1'b0;
              end else seq_cnt <= seq_cnt + SW'(1);

              CFG_POST: if (seq_cnt == GATE_LAST) begin
                state       <= RUN;
                clkout_gate <= '0;
                cfg.cfg_ack <= 1'b1;
                req_armed   <= 1'b0;
              end else seq_cnt <= seq_cnt + SW'(1);

              default: ;
            endcase
          end
        end

        FAULT: if (start) begin
          state     <= PWD;
          seq_cnt   <= '0;
          fault     <= 1'b0;
          retry_cnt <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
